// File: rtl/demux_deser_pkg.sv
// demux_deser_pkg: shared constants and lane state type for the 4-channel deserializer
package demux_deser_pkg;
    localparam int DEMUX_CH    = 4;
    localparam int DEMUX_WIDTH = 8;
    typedef enum logic {COLLECT, STALL} lane_state_t;
endpackage

// File: rtl/demux_deser_lane.sv
// demux_deser_lane: one channel's shift register, bit counter, holding register and stall state
// Bit order is MSB-first when DEMUX_DESER_MSB_FIRST_EN is defined, LSB-first otherwise.
module demux_deser_lane
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             din,
    input  logic             dout_ready,
    output logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH);
    lane_state_t      state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] word;
    logic             take;
    logic             last;
    logic             load;
    assign ready = (state == COLLECT);
    assign take  = bit_en && ready;
    assign last  = (bit_cnt == CW'(WIDTH - 1));
    // A completed word goes straight to hold only if the hold slot is free or being drained now
    assign load  = take && last && (!valid || dout_ready);
    always_comb begin
        word = shift;
`ifdef DEMUX_DESER_MSB_FIRST_EN
        word = {shift[WIDTH-2:0], din};
`else
        word[bit_cnt] = din;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            bit_cnt <= '0;
            shift   <= '0;
            dout    <= '0;
            valid   <= 1'b0;
        end else if (state == STALL) begin
            if (dout_ready) begin
                dout  <= shift;
                state <= COLLECT;
            end
        end else begin
            if (take) begin
                shift   <= word;
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
                if (last && !load) state <= STALL;
            end
            if (load) begin
                dout  <= word;
                valid <= 1'b1;
            end else if (dout_ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/demux_deser_4ch.sv
// demux_deser_4ch: routes serial bits to four deserializer lanes by sel and returns per-lane backpressure
// Optional MSB-first assembly via DEMUX_DESER_MSB_FIRST_EN.
module demux_deser_4ch
    import demux_deser_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_valid,
    input  logic                din,
    input  logic [1:0]          sel,
    output logic                bit_ready,
    output logic [WIDTH-1:0]    dout0,
    output logic [WIDTH-1:0]    dout1,
    output logic [WIDTH-1:0]    dout2,
    output logic [WIDTH-1:0]    dout3,
    output logic [DEMUX_CH-1:0] dout_valid,
    input  logic [DEMUX_CH-1:0] dout_ready
);
    logic [DEMUX_CH-1:0] lane_ready;
    logic [WIDTH-1:0]    lane_dout [DEMUX_CH];
    genvar c;
    generate
        for (c = 0; c < DEMUX_CH; c++) begin : g_lane
            demux_deser_lane #(.WIDTH(WIDTH)) u_lane (
                .clk        (clk),
                .rst        (rst),
                .bit_en     (bit_valid && (sel == 2'(c))),
                .din        (din),
                .dout_ready (dout_ready[c]),
                .ready      (lane_ready[c]),
                .dout       (lane_dout[c]),
                .valid      (dout_valid[c])
            );
        end
    endgenerate
    assign bit_ready = lane_ready[sel];
    assign dout0     = lane_dout[0];
    assign dout1     = lane_dout[1];
    assign dout2     = lane_dout[2];
    assign dout3     = lane_dout[3];
endmodule

// File: tb/tb_demux_deser_4ch.sv
// tb_demux_deser_4ch: directed self-checking bench for demux_deser_4ch (WIDTH=8)
module tb_demux_deser_4ch;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_valid = 1'b0;
    logic       din = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       bit_ready;
    logic [7:0] dout0, dout1, dout2, dout3;
    logic [3:0] dout_valid;
    logic [3:0] dout_ready = 4'b0000;
    int checks = 0;
    int errors = 0;

    demux_deser_4ch dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .din        (din),
        .sel        (sel),
        .bit_ready  (bit_ready),
        .dout0      (dout0),
        .dout1      (dout1),
        .dout2      (dout2),
        .dout3      (dout3),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one bit across exactly one rising edge; returns at the following falling edge
    task automatic send(input logic [1:0] ch, input logic b);
        sel = ch;
        din = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    function automatic logic wbit(input logic [7:0] w, input int k);
`ifdef DEMUX_DESER_MSB_FIRST_EN
        return w[7-k];
`else
        return w[k];
`endif
    endfunction

    task automatic send_bits(input logic [1:0] ch, input logic [7:0] w, input int n);
        for (int k = 0; k < n; k++) send(ch, wbit(w, k));
    endtask

    task automatic probe_ready(input logic [1:0] ch, input string tag, input logic exp);
        sel = ch;
        #1;
        chk(tag, 32'(bit_ready), 32'(exp));
    endtask

    initial begin
        logic [7:0] pat;
        #1;
        chk("reset_valid", 32'(dout_valid), 32'h0);
        chk("reset_dout0", 32'(dout0), 32'h0);
        chk("reset_dout3", 32'(dout3), 32'h0);
        chk("reset_ready", 32'(bit_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        // ch0 word A5 with consumer always ready
        dout_ready = 4'b0001;
        send_bits(2'd0, 8'hA5, 8);
        chk("ch0_dout", 32'(dout0), 32'hA5);
        chk("ch0_valid_one", 32'(dout_valid), 32'b0001);
        @(negedge clk);
        chk("ch0_valid_drop", 32'(dout_valid), 32'b0000);
        // interleaved ch1/ch2
        dout_ready = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            send(2'd1, wbit(8'h3C, k));
            if (k == 7) chk("ilv_ch1_first", 32'(dout_valid), 32'b0010);
            send(2'd2, wbit(8'hC3, k));
        end
        chk("ilv_valid_both", 32'(dout_valid), 32'b0110);
        chk("ilv_dout1", 32'(dout1), 32'h3C);
        chk("ilv_dout2", 32'(dout2), 32'hC3);
        dout_ready = 4'b0110;
        @(negedge clk);
        dout_ready = 4'b0000;
        chk("ilv_consumed", 32'(dout_valid), 32'b0000);
        // ch3 stall with consumer held off
        send_bits(2'd3, 8'h11, 8);
        chk("st_dout3_first", 32'(dout3), 32'h11);
        probe_ready(2'd3, "st_ready_before", 1'b1);
        send_bits(2'd3, 8'h22, 8);
        chk("st_valid", 32'(dout_valid), 32'b1000);
        chk("st_dout3_held", 32'(dout3), 32'h11);
        probe_ready(2'd3, "st_ready_sel3", 1'b0);
        probe_ready(2'd0, "st_ready_sel0", 1'b1);
        send(2'd3, 1'b1);
        chk("st_ignored_bit", 32'(dout3), 32'h11);
        dout_ready = 4'b1000;
        @(negedge clk);
        dout_ready = 4'b0000;
        chk("st_release_dout3", 32'(dout3), 32'h22);
        chk("st_release_valid", 32'(dout_valid), 32'b1000);
        probe_ready(2'd3, "st_ready_after", 1'b1);
        dout_ready = 4'b1000;
        @(negedge clk);
        dout_ready = 4'b0000;
        chk("st_drained", 32'(dout_valid), 32'b0000);
        // no-bubble replace on ch0
        send_bits(2'd0, 8'hA5, 8);
        chk("nb_first", 32'(dout0), 32'hA5);
        pat = 8'h5A;
        for (int k = 0; k < 7; k++) begin
            send(2'd0, wbit(pat, k));
            chk("nb_hold_valid", 32'(dout_valid[0]), 32'h1);
        end
        dout_ready = 4'b0001;
        send(2'd0, wbit(pat, 7));
        dout_ready = 4'b0000;
        chk("nb_dout0", 32'(dout0), 32'h5A);
        chk("nb_valid", 32'(dout_valid), 32'b0001);
        dout_ready = 4'b0001;
        @(negedge clk);
        dout_ready = 4'b0000;
        // reset mid-word on ch1
        send_bits(2'd1, 8'hFF, 5);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(dout_valid), 32'h0);
        chk("rst_async_dout0", 32'(dout0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_bits(2'd1, 8'h0F, 7);
        chk("rst_no_partial", 32'(dout_valid), 32'b0000);
        send(2'd1, wbit(8'h0F, 7));
        chk("rst_dout1", 32'(dout1), 32'h0F);
        chk("rst_valid1", 32'(dout_valid), 32'b0010);
        // palindromic pattern reads A5 in either bit order
        send(2'd2, 1'b1); send(2'd2, 1'b0); send(2'd2, 1'b1); send(2'd2, 1'b0);
        send(2'd2, 1'b0); send(2'd2, 1'b1); send(2'd2, 1'b0); send(2'd2, 1'b1);
        chk("ord_dout2", 32'(dout2), 32'hA5);
        chk("ord_valid", 32'(dout_valid), 32'b0110);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_deser_4ch.md
# demux_deser_4ch

Four-channel bit-serial deserializer that sits directly downstream of the 1:4 bit demultiplexer stage. It takes the serial bit `din` with its 2-bit channel select `sel` and assembles each channel's bits into WIDTH-bit words. Each channel has its own shift register, bit counter and output holding register. Completed words are offered per channel over a valid/ready handshake, with backpressure returned to the bit source.

## Interface
- `WIDTH`, 8: bits per assembled word; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `bit_valid` input 1: `din` and `sel` carry a bit this cycle.
- `din` input 1: serial data bit.
- `sel` input 2: destination channel, 0..3.
- `bit_ready` output 1: the channel addressed by `sel` can accept a bit.
- `dout0`..`dout3` output WIDTH each: holding register of channel 0..3.
- `dout_valid` output 4: bit c means `doutc` holds a complete word.
- `dout_ready` input 4: bit c means the consumer takes `doutc` this cycle.

## Operation
- A bit is accepted on a rising edge when `bit_valid && bit_ready`. It goes only to lane `sel`; other lanes are unaffected.
- Bit order is LSB-first by default: the k-th accepted bit of a word lands in bit k.
- Per-lane state:
  - `bit_cnt`, 0..WIDTH-1.
  - `shift`, WIDTH bits.
  - `hold`, WIDTH bits.
  - `valid`, 1 bit.
  - `state`: COLLECT or STALL.
- COLLECT, bit accepted, `bit_cnt < WIDTH-1`: store the bit and increment `bit_cnt`.
- COLLECT, WIDTH-th bit accepted:
  - Assembled word = `shift` plus the incoming bit.
  - If `valid==0` or `dout_ready[c]==1` this cycle: load the word into `hold`, set `valid=1`, set `bit_cnt=0`, stay in COLLECT.
  - Otherwise: keep the word in `shift`, set `bit_cnt=0`, go to STALL.
- STALL:
  - Lane accepts no bits.
  - On an edge with `valid && dout_ready[c]`: `hold <= shift`, `valid` stays 1, go to COLLECT.
- `bit_ready = (state[sel] == COLLECT)`. It is combinational from registered state and `sel`, and is independent of `bit_valid`.
- Consumer side: on an edge with `valid && dout_ready[c]` and no new word arriving, `valid` clears.
- `hold` retains its value after the word is consumed; `doutc` is meaningful only while valid.
- `dout_ready[c]` while `valid==0` has no effect.
- All four lanes operate in parallel; a stalled lane never blocks the others.

## Timing
- Reset values (asynchronous, immediate):
  - `dout0`..`dout3` = 0.
  - `dout_valid` = 4'b0000.
  - All `bit_cnt` = 0, all lanes in COLLECT.
  - Therefore `bit_ready` = 1.
- Latency: WIDTH-th bit accepted at edge N gives `dout_valid[c]=1` after edge N (visible in cycle N+1).
- Sustained throughput: one bit per cycle per source.
- No-bubble case: a word can be consumed and replaced at the same edge; `dout_valid[c]` stays high.
- STALL release: word moves to `hold` at the consuming edge; `bit_ready` for that lane rises in the following cycle.
- Reset mid-word or mid-stall: partial words and stalled words are discarded; no output is produced for them.
- `sel` may change every cycle.

## Configuration
- `DEMUX_DESER_MSB_FIRST_EN`:
  - Defined: first accepted bit of a word lands in bit WIDTH-1 (shift left, new bit in LSB).
  - Undefined: LSB-first as above.
  - Handshake and timing are identical either way.

## Structure
- Package `demux_deser_pkg` holds:
  - Channel count constant `DEMUX_CH = 4`.
  - Default `WIDTH` constant.
  - Lane state enum `lane_state_t` (COLLECT, STALL).
- Sub-module `demux_deser_lane`: one lane containing shift register, counter, holding register and state. It is instantiated 4 times.
- Top level:
  - Decodes `sel` into per-lane bit strobes.
  - Muxes lane ready flags onto `bit_ready`.

## Test plan
- Reset, then send 8 bits 1,0,1,0,0,1,0,1 on ch0 with `dout_ready[0]=1` -> `dout0`=8'hA5, `dout_valid[0]` high for exactly one cycle after the 8th bit; other `dout_valid` bits stay 0.
- Interleave bits ch1/ch2 alternately, ch1 word 8'h3C and ch2 word 8'hC3 -> both words complete independently with correct values; ch2 valid rises one cycle after ch1.
- Hold `dout_ready[3]=0` and send 16 bits on ch3 (8'h11 then 8'h22):
  - `dout3`=8'h11 and valid; lane STALLs.
  - `bit_ready`=0 whenever `sel`=3 and stays 1 for `sel`=0.
  - Raise `dout_ready[3]` for one cycle -> next cycle `dout3`=8'h22, valid still 1.
- With `dout0`=8'hA5 valid, pulse `dout_ready[0]` on the same edge as the 8th bit of 8'h5A -> `dout0`=8'h5A, `dout_valid[0]` never drops.
- Send 5 bits on ch1, assert `rst` for one cycle, then send 8 bits of 8'h0F -> `dout1`=8'h0F; no word is produced from the discarded partial bits.
- With `DEMUX_DESER_MSB_FIRST_EN` defined, send 1,0,1,0,0,1,0,1 on ch2 -> `dout2`=8'hA5.
